uart_rx: RTL and testbench

- 8N1 UART receiver; counterpart to the team's uart_tx. Same baud divisor convention: div_ratio = f_clk / baud.
- Synchronises the asynchronous rx_line, validates the start bit and samples each bit at mid-bit. Presents each received byte with a one-cycle valid pulse and flags framing errors and overruns.
- Sits between the board UART pin and the AXI-side register block / FIFO.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_line, qualifies the start bit at mid-bit,
// samples data/stop bits at mid-bit and reports good frames, framing errors and overruns.
module uart_rx #(
  parameter int unsigned div_ratio = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(div_ratio + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(div_ratio / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(div_ratio - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  logic          sync1, sync2, prev;
  logic [2:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n, rx_full_n, busy_n, frame_err_n, overrun_n;

  // Two-flop synchroniser plus history flop; all reset high so no edge is seen at reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_line;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_full   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      rx_full   <= rx_full_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state and output logic; the timer restarts from zero on every state entry
  always_comb begin
    state_n     = state;
    timer_n     = timer + TW'(1);
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    rx_full_n   = rx_full;
    frame_err_n = 1'b0;
    overrun_n   = overrun;

    if (rx_ack) begin
      rx_full_n = 1'b0;
      overrun_n = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (!sync2 && prev) state_n = ST_START;
      end
      ST_START: begin
        if (timer == HALF_M1) begin
          timer_n = '0;
          if (sync2) begin
            state_n = ST_IDLE;
          end else begin
            state_n  = ST_DATA;
            bitcnt_n = '0;
          end
        end
      end
      ST_DATA: begin
        if (timer == FULL_M1) begin
          timer_n         = '0;
          shreg_n[bitcnt] = sync2;
          bitcnt_n        = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer == FULL_M1) begin
          timer_n = '0;
          if (sync2) begin
            // A coincident rx_ack loses to the commit and suppresses the overrun
            rx_data_n  = shreg;
            rx_valid_n = 1'b1;
            rx_full_n  = 1'b1;
            if (rx_full && !rx_ack) overrun_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_BRK;
          end
        end
      end
      ST_BRK: begin
        timer_n = '0;
        if (sync2) state_n = ST_IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned DIV = 16;

  logic       clk;
  logic       rst;
  logic       rx_line;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full, busy, frame_err, overrun;

  uart_rx #(.div_ratio(DIV)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Output monitor
  int         valid_cnt = 0;
  int         fe_cnt = 0;
  int         last_valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      last_data = rx_data;
    end
    if (frame_err) fe_cnt++;
  end

  // Reference model at the level of whole frames and acknowledgements
  logic [7:0] m_data = 8'h00;
  logic       m_full = 1'b0;
  logic       m_over = 1'b0;

  task automatic model_good(input logic [7:0] b, input logic ack);
    if (m_full && !ack) m_over = 1'b1;
    if (ack) m_over = 1'b0;
    m_full = 1'b1;
    m_data = b;
  endtask

  task automatic model_ack();
    m_full = 1'b0;
    m_over = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int fall_cyc = 0;

  task automatic send_bit(input logic v);
    rx_line = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  int lat;
  int v0, f0, bc;
  logic [7:0] rb, xb;

  initial begin
    rst = 1'b0;
    rx_line = 1'b0;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({rx_data, rx_valid, rx_full, busy, frame_err, overrun}), 32'h0);

    // Line held low from reset release must not yield a frame
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("low_line_no_frame", 32'(valid_cnt), 32'd0);
    chk("low_line_not_full", 32'(rx_full), 32'd0);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    chk("low_line_idle", 32'(busy), 32'd0);

    // Basic frame 0xA5
    f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    model_good(8'hA5, 1'b0);
    lat = last_valid_cyc - fall_cyc;
    chk("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("a5_latency", 32'(lat >= 154 && lat <= 156), 32'd1);
    chk("a5_data", 32'(rx_data), 32'(m_data));
    chk("a5_full", 32'(rx_full), 32'(m_full));
    chk("a5_no_ferr", 32'(fe_cnt), 32'(f0));
    if (lat < 2) lat = 155;

    // Short low glitch
    v0 = valid_cnt;
    f0 = fe_cnt;
    bc = 0;
    rx_line = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx_line = 1'b1;
      @(negedge clk);
      if (busy) bc++;
    end
    chk("glitch_busy_len", 32'(bc >= 7 && bc <= 11), 32'd1);
    chk("glitch_no_valid", 32'(valid_cnt), 32'(v0));
    chk("glitch_no_ferr", 32'(fe_cnt), 32'(f0));
    chk("glitch_idle", 32'(busy), 32'd0);

    // Framing error: stop bit low, line released 40 cycles later
    v0 = valid_cnt;
    f0 = fe_cnt;
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(xb_bit(8'h3C, i));
    rx_line = 1'b0;
    repeat (40) @(negedge clk);
    chk("ferr_pulse", 32'(fe_cnt), 32'(f0 + 1));
    chk("ferr_busy_low", 32'(busy), 32'd1);
    rx_line = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_busy_release", 32'(busy), 32'd0);
    chk("ferr_data_kept", 32'(rx_data), 32'(m_data));
    chk("ferr_full_kept", 32'(rx_full), 32'(m_full));
    chk("ferr_no_valid", 32'(valid_cnt), 32'(v0));

    pulse_ack();
    model_ack();
    chk("ack_full", 32'(rx_full), 32'(m_full));
    chk("ack_over", 32'(overrun), 32'(m_over));

    // Back-to-back frames without acknowledge
    v0 = valid_cnt;
    send_frame(8'h01, 1'b1);
    model_good(8'h01, 1'b0);
    send_frame(8'hFF, 1'b1);
    model_good(8'hFF, 1'b0);
    chk("b2b_valid_cnt", 32'(valid_cnt), 32'(v0 + 2));
    chk("b2b_data", 32'(rx_data), 32'(m_data));
    chk("b2b_full", 32'(rx_full), 32'(m_full));
    chk("b2b_overrun", 32'(overrun), 32'(m_over));
    pulse_ack();
    model_ack();
    chk("b2b_ack_full", 32'(rx_full), 32'(m_full));
    chk("b2b_ack_over", 32'(overrun), 32'(m_over));

    // Acknowledge coinciding with a commit while full
    xb = 8'($urandom);
    send_frame(xb, 1'b1);
    model_good(xb, 1'b0);
    rb = 8'($urandom);
    fork
      send_frame(rb, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    model_good(rb, 1'b1);
    chk("coinc_data", 32'(rx_data), 32'(m_data));
    chk("coinc_full", 32'(rx_full), 32'(m_full));
    chk("coinc_over", 32'(overrun), 32'(m_over));

    // Randomized frames, gaps and acknowledges
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      v0 = valid_cnt;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_frame(rb, 1'b1);
      model_good(rb, 1'b0);
      chk("rand_valid", 32'(valid_cnt), 32'(v0 + 1));
      chk("rand_data", 32'(last_data), 32'(rb));
      chk("rand_full", 32'(rx_full), 32'(m_full));
      chk("rand_over", 32'(overrun), 32'(m_over));
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        model_ack();
        chk("rand_ack_full", 32'(rx_full), 32'(m_full));
      end
    end

    // Reset in the middle of data bit 4, then a clean frame
    v0 = valid_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (5 * DIV + DIV / 2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_outputs", 32'({rx_data, rx_valid, rx_full, busy, frame_err, overrun}), 32'h0);
      end
    join
    m_data = 8'h00;
    model_ack();
    chk("midreset_no_valid", 32'(valid_cnt), 32'(v0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    model_good(8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_reset_valid", 32'(valid_cnt), 32'(v0 + 1));
    chk("post_reset_data", 32'(rx_data), 32'(m_data));
    chk("post_reset_full", 32'(rx_full), 32'(m_full));
    chk("post_reset_over", 32'(overrun), 32'(m_over));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic xb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
